// File: rtl/multi_channel_mux_if.sv
// Bus bundle for multi_channel_mux: four read channels, memory read/write ports and the channel-0 write path.
// The slave modport is the mux view and the master modport is the surrounding shim.
interface multi_channel_mux_if #(
   parameter int RD_REQ_W  = 80,
   parameter int RD_RESP_W = 528,
   parameter int WR_REQ_W  = 606,
   parameter int WR_RESP_W = 17
) ();
   logic                 io_acc_rd_req_in_0_valid, io_acc_rd_req_in_1_valid;
   logic                 io_acc_rd_req_in_2_valid, io_acc_rd_req_in_3_valid;
   logic [RD_REQ_W-1:0]  io_acc_rd_req_in_0_bits, io_acc_rd_req_in_1_bits;
   logic [RD_REQ_W-1:0]  io_acc_rd_req_in_2_bits, io_acc_rd_req_in_3_bits;
   logic                 io_acc_rd_req_in_0_ready, io_acc_rd_req_in_1_ready;
   logic                 io_acc_rd_req_in_2_ready, io_acc_rd_req_in_3_ready;

   logic                 io_mem_rd_req_out_valid;
   logic [RD_REQ_W-1:0]  io_mem_rd_req_out_bits;
   logic                 io_mem_rd_req_out_ready;

   logic                 io_mem_rd_resp_in_valid;
   logic [RD_RESP_W-1:0] io_mem_rd_resp_in_bits;
   logic                 io_mem_rd_resp_in_ready;

   logic                 io_acc_rd_resp_out_0_valid, io_acc_rd_resp_out_1_valid;
   logic                 io_acc_rd_resp_out_2_valid, io_acc_rd_resp_out_3_valid;
   logic [RD_RESP_W-1:0] io_acc_rd_resp_out_0_bits, io_acc_rd_resp_out_1_bits;
   logic [RD_RESP_W-1:0] io_acc_rd_resp_out_2_bits, io_acc_rd_resp_out_3_bits;
   logic                 io_acc_rd_resp_out_0_ready, io_acc_rd_resp_out_1_ready;
   logic                 io_acc_rd_resp_out_2_ready, io_acc_rd_resp_out_3_ready;

   logic                 io_acc_wr_req_in_0_valid;
   logic [WR_REQ_W-1:0]  io_acc_wr_req_in_0_bits;
   logic                 io_acc_wr_req_in_0_ready;
   logic                 io_mem_wr_req_out_valid;
   logic [WR_REQ_W-1:0]  io_mem_wr_req_out_bits;
   logic                 io_mem_wr_req_out_ready;
   logic                 io_mem_wr_resp_in_valid;
   logic [WR_RESP_W-1:0] io_mem_wr_resp_in_bits;
   logic                 io_mem_wr_resp_in_ready;
   logic                 io_acc_wr_resp_out_0_valid;
   logic [WR_RESP_W-1:0] io_acc_wr_resp_out_0_bits;
   logic                 io_acc_wr_resp_out_0_ready;

   modport slave (
      input  io_acc_rd_req_in_0_valid, io_acc_rd_req_in_1_valid,
             io_acc_rd_req_in_2_valid, io_acc_rd_req_in_3_valid,
             io_acc_rd_req_in_0_bits, io_acc_rd_req_in_1_bits,
             io_acc_rd_req_in_2_bits, io_acc_rd_req_in_3_bits,
      output io_acc_rd_req_in_0_ready, io_acc_rd_req_in_1_ready,
             io_acc_rd_req_in_2_ready, io_acc_rd_req_in_3_ready,
      output io_mem_rd_req_out_valid, io_mem_rd_req_out_bits,
      input  io_mem_rd_req_out_ready,
      input  io_mem_rd_resp_in_valid, io_mem_rd_resp_in_bits,
      output io_mem_rd_resp_in_ready,
      output io_acc_rd_resp_out_0_valid, io_acc_rd_resp_out_1_valid,
             io_acc_rd_resp_out_2_valid, io_acc_rd_resp_out_3_valid,
             io_acc_rd_resp_out_0_bits, io_acc_rd_resp_out_1_bits,
             io_acc_rd_resp_out_2_bits, io_acc_rd_resp_out_3_bits,
      input  io_acc_rd_resp_out_0_ready, io_acc_rd_resp_out_1_ready,
             io_acc_rd_resp_out_2_ready, io_acc_rd_resp_out_3_ready,
      input  io_acc_wr_req_in_0_valid, io_acc_wr_req_in_0_bits,
      output io_acc_wr_req_in_0_ready,
      output io_mem_wr_req_out_valid, io_mem_wr_req_out_bits,
      input  io_mem_wr_req_out_ready,
      input  io_mem_wr_resp_in_valid, io_mem_wr_resp_in_bits,
      output io_mem_wr_resp_in_ready,
      output io_acc_wr_resp_out_0_valid, io_acc_wr_resp_out_0_bits,
      input  io_acc_wr_resp_out_0_ready
   );

   modport master (
      output io_acc_rd_req_in_0_valid, io_acc_rd_req_in_1_valid,
             io_acc_rd_req_in_2_valid, io_acc_rd_req_in_3_valid,
             io_acc_rd_req_in_0_bits, io_acc_rd_req_in_1_bits,
             io_acc_rd_req_in_2_bits, io_acc_rd_req_in_3_bits,
      input  io_acc_rd_req_in_0_ready, io_acc_rd_req_in_1_ready,
             io_acc_rd_req_in_2_ready, io_acc_rd_req_in_3_ready,
      input  io_mem_rd_req_out_valid, io_mem_rd_req_out_bits,
      output io_mem_rd_req_out_ready,
      output io_mem_rd_resp_in_valid, io_mem_rd_resp_in_bits,
      input  io_mem_rd_resp_in_ready,
      input  io_acc_rd_resp_out_0_valid, io_acc_rd_resp_out_1_valid,
             io_acc_rd_resp_out_2_valid, io_acc_rd_resp_out_3_valid,
             io_acc_rd_resp_out_0_bits, io_acc_rd_resp_out_1_bits,
             io_acc_rd_resp_out_2_bits, io_acc_rd_resp_out_3_bits,
      output io_acc_rd_resp_out_0_ready, io_acc_rd_resp_out_1_ready,
             io_acc_rd_resp_out_2_ready, io_acc_rd_resp_out_3_ready,
      output io_acc_wr_req_in_0_valid, io_acc_wr_req_in_0_bits,
      input  io_acc_wr_req_in_0_ready,
      input  io_mem_wr_req_out_valid, io_mem_wr_req_out_bits,
      output io_mem_wr_req_out_ready,
      output io_mem_wr_resp_in_valid, io_mem_wr_resp_in_bits,
      input  io_mem_wr_resp_in_ready,
      input  io_acc_wr_resp_out_0_valid, io_acc_wr_resp_out_0_bits,
      output io_acc_wr_resp_out_0_ready
   );
endinterface

// File: rtl/multi_channel_mux.sv
// Round-robin read-request mux with ID tagging, ID-routed read responses and a write pass-through.
// Optional macro MULTI_CHANNEL_MUX_CHECK_EN adds a simulation-only response back-pressure check.
module multi_channel_mux #(
   parameter int RD_REQ_W  = 80,
   parameter int RD_RESP_W = 528,
   parameter int WR_REQ_W  = 606,
   parameter int WR_RESP_W = 17
) (
   input logic                 clk,
   input logic                 rst,
   multi_channel_mux_if.slave  bus
);
   logic [3:0]          req_valid;
   logic [RD_REQ_W-1:0] req_bits [4];
   logic [3:0]          in_ready;
   logic                reg_can_load;
   logic                grant_found;
   logic [1:0]          grant_idx;
   logic                accept;

   logic                out_valid_d, out_valid_q;
   logic [RD_REQ_W-1:0] out_bits_d, out_bits_q;
   logic [1:0]          last_grant_d, last_grant_q;

   logic [1:0]          resp_id;
   logic [3:0]          resp_ready_vec;

   assign req_valid = {bus.io_acc_rd_req_in_3_valid, bus.io_acc_rd_req_in_2_valid,
                       bus.io_acc_rd_req_in_1_valid, bus.io_acc_rd_req_in_0_valid};
   assign req_bits[0] = bus.io_acc_rd_req_in_0_bits;
   assign req_bits[1] = bus.io_acc_rd_req_in_1_bits;
   assign req_bits[2] = bus.io_acc_rd_req_in_2_bits;
   assign req_bits[3] = bus.io_acc_rd_req_in_3_bits;

   assign bus.io_acc_rd_req_in_0_ready = in_ready[0];
   assign bus.io_acc_rd_req_in_1_ready = in_ready[1];
   assign bus.io_acc_rd_req_in_2_ready = in_ready[2];
   assign bus.io_acc_rd_req_in_3_ready = in_ready[3];

   // Search starts one past the last winner so every channel gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_grant_q;
      for (int k = 1; k <= 4; k++) begin
         if (!grant_found && req_valid[last_grant_q + 2'(k)]) begin
            grant_found = 1'b1;
            grant_idx   = last_grant_q + 2'(k);
         end
      end
   end

   always_comb begin
      reg_can_load = !out_valid_q || bus.io_mem_rd_req_out_ready;
      accept       = rst && grant_found && reg_can_load;
      in_ready     = accept ? (4'b0001 << grant_idx) : 4'b0000;
      out_valid_d  = reg_can_load ? accept : out_valid_q;
      out_bits_d   = out_bits_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         out_bits_d   = {grant_idx, req_bits[grant_idx][RD_REQ_W-3:0]};
         last_grant_d = grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q  <= 1'b0;
         out_bits_q   <= '0;
         last_grant_q <= 2'd3;
      end else begin
         out_valid_q  <= out_valid_d;
         out_bits_q   <= out_bits_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.io_mem_rd_req_out_valid = out_valid_q;
   assign bus.io_mem_rd_req_out_bits  = out_bits_q;

   // Responses carry their channel ID in the top two bits and are routed on it untouched.
   assign resp_id        = bus.io_mem_rd_resp_in_bits[RD_RESP_W-1 -: 2];
   assign resp_ready_vec = {bus.io_acc_rd_resp_out_3_ready, bus.io_acc_rd_resp_out_2_ready,
                            bus.io_acc_rd_resp_out_1_ready, bus.io_acc_rd_resp_out_0_ready};

   assign bus.io_acc_rd_resp_out_0_valid = bus.io_mem_rd_resp_in_valid && (resp_id == 2'd0);
   assign bus.io_acc_rd_resp_out_1_valid = bus.io_mem_rd_resp_in_valid && (resp_id == 2'd1);
   assign bus.io_acc_rd_resp_out_2_valid = bus.io_mem_rd_resp_in_valid && (resp_id == 2'd2);
   assign bus.io_acc_rd_resp_out_3_valid = bus.io_mem_rd_resp_in_valid && (resp_id == 2'd3);
   assign bus.io_acc_rd_resp_out_0_bits  = bus.io_mem_rd_resp_in_bits;
   assign bus.io_acc_rd_resp_out_1_bits  = bus.io_mem_rd_resp_in_bits;
   assign bus.io_acc_rd_resp_out_2_bits  = bus.io_mem_rd_resp_in_bits;
   assign bus.io_acc_rd_resp_out_3_bits  = bus.io_mem_rd_resp_in_bits;
   assign bus.io_mem_rd_resp_in_ready    = resp_ready_vec[resp_id];

   assign bus.io_mem_wr_req_out_valid    = bus.io_acc_wr_req_in_0_valid;
   assign bus.io_mem_wr_req_out_bits     = bus.io_acc_wr_req_in_0_bits;
   assign bus.io_acc_wr_req_in_0_ready   = bus.io_mem_wr_req_out_ready;
   assign bus.io_acc_wr_resp_out_0_valid = bus.io_mem_wr_resp_in_valid;
   assign bus.io_acc_wr_resp_out_0_bits  = bus.io_mem_wr_resp_in_bits;
   assign bus.io_mem_wr_resp_in_ready    = bus.io_acc_wr_resp_out_0_ready;

`ifdef MULTI_CHANNEL_MUX_CHECK_EN
   // Responses must never be stalled upstream of this mux; flag it loudly in simulation.
   always @(posedge clk) begin
      if (rst) begin
         if ((bus.io_mem_rd_resp_in_valid && !bus.io_mem_rd_resp_in_ready) ||
             (bus.io_mem_wr_resp_in_valid && !bus.io_mem_wr_resp_in_ready)) begin
            $display("Error(MultiChannelMux): response back-pressure %m @ %0d", $time);
            $stop;
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_multi_channel_mux.sv
// Self-checking bench for multi_channel_mux: directed vectors, a cycle-level reference model
// compared every cycle, and literal expectations pinning that model.
module tb_multi_channel_mux;
   logic clk;
   logic rst;
   logic check_on;
   int   checks;
   int   failures;

   multi_channel_mux_if bus ();

   multi_channel_mux dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: one request slot and the last channel granted.
   logic        m_full;
   logic [79:0] m_bits;
   int          m_last;

   task automatic checkOutput(input string name, input logic [607:0] act, input logic [607:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] rd_valids();
      return {bus.io_acc_rd_req_in_3_valid, bus.io_acc_rd_req_in_2_valid,
              bus.io_acc_rd_req_in_1_valid, bus.io_acc_rd_req_in_0_valid};
   endfunction

   function automatic logic [79:0] rd_bits(input int n);
      case (n)
         0: return bus.io_acc_rd_req_in_0_bits;
         1: return bus.io_acc_rd_req_in_1_bits;
         2: return bus.io_acc_rd_req_in_2_bits;
         default: return bus.io_acc_rd_req_in_3_bits;
      endcase
   endfunction

   function automatic logic [3:0] rd_readys();
      return {bus.io_acc_rd_req_in_3_ready, bus.io_acc_rd_req_in_2_ready,
              bus.io_acc_rd_req_in_1_ready, bus.io_acc_rd_req_in_0_ready};
   endfunction

   function automatic logic [3:0] resp_valids();
      return {bus.io_acc_rd_resp_out_3_valid, bus.io_acc_rd_resp_out_2_valid,
              bus.io_acc_rd_resp_out_1_valid, bus.io_acc_rd_resp_out_0_valid};
   endfunction

   function automatic logic [527:0] resp_bits(input int n);
      case (n)
         0: return bus.io_acc_rd_resp_out_0_bits;
         1: return bus.io_acc_rd_resp_out_1_bits;
         2: return bus.io_acc_rd_resp_out_2_bits;
         default: return bus.io_acc_rd_resp_out_3_bits;
      endcase
   endfunction

   function automatic logic [3:0] acc_resp_readys();
      return {bus.io_acc_rd_resp_out_3_ready, bus.io_acc_rd_resp_out_2_ready,
              bus.io_acc_rd_resp_out_1_ready, bus.io_acc_rd_resp_out_0_ready};
   endfunction

   // Round-robin winner: first valid channel counting upward from one past the last grant.
   function automatic int pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (v[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int          g;
      logic [79:0] b;
      if (!rst) begin
         m_full = 1'b0;
         m_last = 3;
      end else if (!m_full || bus.io_mem_rd_req_out_ready) begin
         g = pick(rd_valids(), m_last);
         if (g >= 0) begin
            b      = rd_bits(g);
            m_bits = {2'(g), b[77:0]};
            m_full = 1'b1;
            m_last = g;
         end else begin
            m_full = 1'b0;
         end
      end
   end

   // Every cycle: compare all outputs against what the rules demand for the current inputs and model state.
   always @(negedge clk) begin
      int         g;
      int         id;
      logic       can_load;
      logic [3:0] exp_rdy;
      if (check_on) begin
         g        = pick(rd_valids(), m_last);
         can_load = !m_full || bus.io_mem_rd_req_out_ready;
         exp_rdy  = (rst && can_load && g >= 0) ? 4'(1 << g) : 4'b0000;
         checkOutput("rd_out_valid", 608'(bus.io_mem_rd_req_out_valid), 608'(m_full));
         if (m_full) checkOutput("rd_out_bits", 608'(bus.io_mem_rd_req_out_bits), 608'(m_bits));
         checkOutput("rd_in_ready", 608'(rd_readys()), 608'(exp_rdy));
         id = int'(bus.io_mem_rd_resp_in_bits[527:526]);
         checkOutput("resp_valids", 608'(resp_valids()),
                     608'(bus.io_mem_rd_resp_in_valid ? 4'(1 << id) : 4'b0000));
         for (int n = 0; n < 4; n++)
            checkOutput("resp_bits", 608'(resp_bits(n)), 608'(bus.io_mem_rd_resp_in_bits));
         checkOutput("resp_in_ready", 608'(bus.io_mem_rd_resp_in_ready), 608'(acc_resp_readys() >> id & 4'b1));
         checkOutput("wr_req_valid", 608'(bus.io_mem_wr_req_out_valid), 608'(bus.io_acc_wr_req_in_0_valid));
         checkOutput("wr_req_bits", 608'(bus.io_mem_wr_req_out_bits), 608'(bus.io_acc_wr_req_in_0_bits));
         checkOutput("wr_req_ready", 608'(bus.io_acc_wr_req_in_0_ready), 608'(bus.io_mem_wr_req_out_ready));
         checkOutput("wr_resp_valid", 608'(bus.io_acc_wr_resp_out_0_valid), 608'(bus.io_mem_wr_resp_in_valid));
         checkOutput("wr_resp_bits", 608'(bus.io_acc_wr_resp_out_0_bits), 608'(bus.io_mem_wr_resp_in_bits));
         checkOutput("wr_resp_ready", 608'(bus.io_mem_wr_resp_in_ready), 608'(bus.io_acc_wr_resp_out_0_ready));
      end
   end

   task automatic set_rd_valid(input logic [3:0] v);
      bus.io_acc_rd_req_in_0_valid = v[0];
      bus.io_acc_rd_req_in_1_valid = v[1];
      bus.io_acc_rd_req_in_2_valid = v[2];
      bus.io_acc_rd_req_in_3_valid = v[3];
   endtask

   task automatic set_resp_ready(input logic [3:0] r);
      bus.io_acc_rd_resp_out_0_ready = r[0];
      bus.io_acc_rd_resp_out_1_ready = r[1];
      bus.io_acc_rd_resp_out_2_ready = r[2];
      bus.io_acc_rd_resp_out_3_ready = r[3];
   endtask

   task automatic init_inputs();
      set_rd_valid(4'b0000);
      bus.io_acc_rd_req_in_0_bits = '0;
      bus.io_acc_rd_req_in_1_bits = '0;
      bus.io_acc_rd_req_in_2_bits = '0;
      bus.io_acc_rd_req_in_3_bits = '0;
      bus.io_mem_rd_req_out_ready = 1'b0;
      bus.io_mem_rd_resp_in_valid = 1'b0;
      bus.io_mem_rd_resp_in_bits  = '0;
      set_resp_ready(4'b1111);
      bus.io_acc_wr_req_in_0_valid   = 1'b0;
      bus.io_acc_wr_req_in_0_bits    = '0;
      bus.io_mem_wr_req_out_ready    = 1'b0;
      bus.io_mem_wr_resp_in_valid    = 1'b0;
      bus.io_mem_wr_resp_in_bits     = '0;
      bus.io_acc_wr_resp_out_0_ready = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      check_on = 1'b0;
      m_full   = 1'b0;
      m_bits   = '0;
      m_last   = 3;
      rst      = 1'b0;
      init_inputs();
      bus.io_acc_rd_req_in_0_valid = 1'b1;
      applyStimulus(1);
      check_on = 1'b1;
      applyStimulus(1);
      checkOutput("reset_out_valid", 608'(bus.io_mem_rd_req_out_valid), 608'(0));
      checkOutput("reset_in0_ready", 608'(bus.io_acc_rd_req_in_0_ready), 608'(0));

      $display("[TB] all four channels streaming");
      bus.io_acc_rd_req_in_0_bits = {2'b11, 62'h0, 16'h0000};
      bus.io_acc_rd_req_in_1_bits = {2'b11, 62'h0, 16'h0001};
      bus.io_acc_rd_req_in_2_bits = {2'b11, 62'h0, 16'h0002};
      bus.io_acc_rd_req_in_3_bits = {2'b11, 62'h0, 16'h0003};
      set_rd_valid(4'b1111);
      bus.io_mem_rd_req_out_ready = 1'b1;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1);
         checkOutput("t1_valid", 608'(bus.io_mem_rd_req_out_valid), 608'(1));
         checkOutput("t1_chan_id", 608'(bus.io_mem_rd_req_out_bits[79:78]), 608'(k));
         checkOutput("t1_payload", 608'(bus.io_mem_rd_req_out_bits[15:0]), 608'(k));
      end
      applyStimulus(1);
      checkOutput("t1_wrap_id", 608'(bus.io_mem_rd_req_out_bits[79:78]), 608'(0));
      applyStimulus(3);

      $display("[TB] single channel with output stall");
      set_rd_valid(4'b0000);
      applyStimulus(1);
      bus.io_acc_rd_req_in_2_bits = 80'h0000_0000_0000_0000_ABCD;
      set_rd_valid(4'b0100);
      bus.io_mem_rd_req_out_ready = 1'b0;
      #1;
      checkOutput("t2_in2_ready_empty", 608'(bus.io_acc_rd_req_in_2_ready), 608'(1));
      applyStimulus(1);
      for (int k = 0; k < 5; k++) begin
         checkOutput("t2_hold_valid", 608'(bus.io_mem_rd_req_out_valid), 608'(1));
         checkOutput("t2_hold_bits", 608'(bus.io_mem_rd_req_out_bits), 608'(80'h8000_0000_0000_0000_ABCD));
         checkOutput("t2_in2_ready_full", 608'(bus.io_acc_rd_req_in_2_ready), 608'(0));
         applyStimulus(1);
      end
      set_rd_valid(4'b0000);
      bus.io_mem_rd_req_out_ready = 1'b1;
      applyStimulus(1);
      checkOutput("t2_drained", 608'(bus.io_mem_rd_req_out_valid), 608'(0));

      $display("[TB] response routing");
      bus.io_mem_rd_resp_in_bits  = {2'd3, 526'h1234_5678};
      bus.io_mem_rd_resp_in_valid = 1'b1;
      set_resp_ready(4'b0111);
      #1;
      checkOutput("t3_valids", 608'(resp_valids()), 608'(4'b1000));
      checkOutput("t3_bits_id", 608'(bus.io_acc_rd_resp_out_3_bits[527:526]), 608'(3));
      checkOutput("t3_ready_low", 608'(bus.io_mem_rd_resp_in_ready), 608'(0));
      set_resp_ready(4'b1000);
      #1;
      checkOutput("t3_ready_high", 608'(bus.io_mem_rd_resp_in_ready), 608'(1));
      applyStimulus(1);
      bus.io_mem_rd_resp_in_bits = {2'd1, 526'hBEEF};
      #1;
      checkOutput("t3_valids_ch1", 608'(resp_valids()), 608'(4'b0010));
      checkOutput("t3_ready_ch1", 608'(bus.io_mem_rd_resp_in_ready), 608'(0));
      applyStimulus(1);
      bus.io_mem_rd_resp_in_valid = 1'b0;
      set_resp_ready(4'b1111);

      $display("[TB] write pass-through");
      bus.io_acc_wr_req_in_0_bits  = 606'h5A_A5A5_0001;
      bus.io_acc_wr_req_in_0_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.io_mem_wr_req_out_ready = i[0];
         #1;
         checkOutput("t4_wr_bits", 608'(bus.io_mem_wr_req_out_bits), 608'(606'h5A_A5A5_0001));
         checkOutput("t4_wr_ready", 608'(bus.io_acc_wr_req_in_0_ready), 608'(i[0]));
         applyStimulus(1);
      end
      bus.io_acc_wr_req_in_0_valid = 1'b0;
      bus.io_mem_wr_resp_in_bits   = 17'h1_0003;
      bus.io_mem_wr_resp_in_valid  = 1'b1;
      #1;
      checkOutput("t4_resp_valid", 608'(bus.io_acc_wr_resp_out_0_valid), 608'(1));
      checkOutput("t4_resp_bits", 608'(bus.io_acc_wr_resp_out_0_bits), 608'(17'h1_0003));
      applyStimulus(1);
      bus.io_mem_wr_resp_in_valid = 1'b0;

      $display("[TB] reset drops a buffered request");
      bus.io_acc_rd_req_in_0_bits = 80'h1234;
      bus.io_acc_rd_req_in_1_bits = 80'h5678;
      set_rd_valid(4'b0001);
      bus.io_mem_rd_req_out_ready = 1'b0;
      applyStimulus(1);
      set_rd_valid(4'b0000);
      checkOutput("t5_buffered", 608'(bus.io_mem_rd_req_out_valid), 608'(1));
      rst = 1'b0;
      applyStimulus(1);
      checkOutput("t5_dropped", 608'(bus.io_mem_rd_req_out_valid), 608'(0));
      rst = 1'b1;
      set_rd_valid(4'b0011);
      bus.io_mem_rd_req_out_ready = 1'b1;
      applyStimulus(1);
      checkOutput("t5_first_ch0", 608'(bus.io_mem_rd_req_out_bits), 608'(80'h1234));
      applyStimulus(1);
      checkOutput("t5_then_ch1", 608'(bus.io_mem_rd_req_out_bits), 608'(80'h4000_0000_0000_0000_5678));

      $display("[TB] mixed traffic");
      for (int c = 0; c < 60; c++) begin
         set_rd_valid(4'($urandom_range(0, 15)));
         bus.io_acc_rd_req_in_0_bits = 80'({$urandom(), $urandom(), $urandom()});
         bus.io_acc_rd_req_in_1_bits = 80'({$urandom(), $urandom(), $urandom()});
         bus.io_acc_rd_req_in_2_bits = 80'({$urandom(), $urandom(), $urandom()});
         bus.io_acc_rd_req_in_3_bits = 80'({$urandom(), $urandom(), $urandom()});
         bus.io_mem_rd_req_out_ready = 1'($urandom_range(0, 1));
         bus.io_mem_rd_resp_in_valid = 1'($urandom_range(0, 1));
         bus.io_mem_rd_resp_in_bits  = {2'($urandom_range(0, 3)), 526'({$urandom(), $urandom()})};
         set_resp_ready(4'($urandom_range(0, 15)));
         bus.io_acc_wr_req_in_0_valid   = 1'($urandom_range(0, 1));
         bus.io_acc_wr_req_in_0_bits    = 606'({$urandom(), $urandom()});
         bus.io_mem_wr_req_out_ready    = 1'($urandom_range(0, 1));
         bus.io_mem_wr_resp_in_valid    = 1'($urandom_range(0, 1));
         bus.io_mem_wr_resp_in_bits     = 17'($urandom());
         bus.io_acc_wr_resp_out_0_ready = 1'($urandom_range(0, 1));
         rst = (c == 30) ? 1'b0 : 1'b1;
         applyStimulus(1);
      end
      rst = 1'b1;
      init_inputs();
      applyStimulus(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
